// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM encoding and opcode decode helpers for iterative_muldiv.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Divide family: DIV, DIVU, REM, REMU.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Remainder ops return the remainder instead of the quotient.
  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is signed for MUL, MULH, DIV, REM.
  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/iterative_muldiv_if.sv
// Request/response bundle of iterative_muldiv.
// Handshake rule for both channels: a transfer happens on a rising edge where
// VALID and READY are both 1; once raised, OUT_VALID and its payload (Y/DZ/OF)
// stay constant until that transfer; READY may be driven independently of VALID.
interface iterative_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [2:0]       OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] Y;
  logic             DZ;
  logic             OF;

  modport master (
    output IN_VALID, OP, A, B, OUT_READY,
    input  IN_READY, OUT_VALID, Y, DZ, OF
  );

  modport slave (
    input  IN_VALID, OP, A, B, OUT_READY,
    output IN_READY, OUT_VALID, Y, DZ, OF
  );
endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and the
// final result sign fix.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  assign q = neg ? -d : d;
endmodule

// File: rtl/iterative_muldiv.sv
// Multi-cycle RV32M multiply/divide: radix-2 shift-add multiplier and restoring
// divider sharing one accumulator/shift register pair.
module iterative_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                CLK,
  input  logic                RST,
  iterative_muldiv_if.slave   bus,
  output state_t              dbg_state
);
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [2:0]       op_r;
  logic [WIDTH:0]   m_r;        // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_r;      // product high half / partial remainder
  logic [WIDTH-1:0] q_r;        // multiplier -> product low half / dividend -> quotient
  logic [CW-1:0]    cnt_r;
  logic             res_sign_r, dz_pend_r, of_pend_r;
  logic [WIDTH-1:0] y_r;
  logic             dz_r, of_r;

  // Operand decode in IDLE; magnitudes keep WIDTH+1 bits so the most-negative
  // value survives negation.
  logic             sa, sb, div_zero, div_ovf, req_sign;
  logic [WIDTH:0]   mag_a, mag_b;

  assign sa = is_signed_a(bus.OP) & bus.A[WIDTH-1];
  assign sb = is_signed_b(bus.OP) & bus.B[WIDTH-1];

  muldiv_negate #(.W(WIDTH+1)) u_neg_a (.neg(sa), .d({sa, bus.A}), .q(mag_a));
  muldiv_negate #(.W(WIDTH+1)) u_neg_b (.neg(sb), .d({sb, bus.B}), .q(mag_b));

  assign div_zero = is_div(bus.OP) && (bus.B == '0);
  assign div_ovf  = is_div(bus.OP) && is_signed_a(bus.OP) && !div_zero &&
                    (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);
  assign req_sign = is_rem(bus.OP) ? sa : (sa ^ sb);

  // One iteration step of each algorithm.
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  assign mul_sum   = {1'b0, acc_r} + (q_r[0] ? m_r : '0);
  assign div_shift = {acc_r, q_r[WIDTH-1]};
  assign div_ge    = div_shift >= m_r;
  assign div_diff  = div_shift[WIDTH-1:0] - m_r[WIDTH-1:0];

  // Sign fix on the full 2*WIDTH product or the zero-extended quotient/remainder.
  logic [2*WIDTH-1:0] fix_in, fix_out;
  logic [WIDTH-1:0]   res_y;

  assign fix_in = !is_div(op_r) ? {acc_r, q_r} :
                  is_rem(op_r)  ? {{WIDTH{1'b0}}, acc_r} : {{WIDTH{1'b0}}, q_r};

  muldiv_negate #(.W(2*WIDTH)) u_neg_res (.neg(res_sign_r), .d(fix_in), .q(fix_out));

  assign res_y = (!is_div(op_r) && (op_r != OP_MUL)) ? fix_out[2*WIDTH-1:WIDTH]
                                                     : fix_out[WIDTH-1:0];

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (bus.IN_VALID) state_nx = (div_zero || div_ovf) ? ST_FIN : ST_CALC;
      ST_CALC: if (cnt_r == '0) state_nx = ST_FIN;
      ST_FIN:  state_nx = ST_HOLD;
      ST_HOLD: if (bus.OUT_READY) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath: latch request, iterate, register the result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_r       <= '0;
      m_r        <= '0;
      acc_r      <= '0;
      q_r        <= '0;
      cnt_r      <= '0;
      res_sign_r <= 1'b0;
      dz_pend_r  <= 1'b0;
      of_pend_r  <= 1'b0;
      y_r        <= '0;
      dz_r       <= 1'b0;
      of_r       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.IN_VALID) begin
          op_r      <= bus.OP;
          cnt_r     <= CW'(WIDTH-1);
          dz_pend_r <= div_zero;
          of_pend_r <= div_ovf;
          acc_r     <= '0;
          if (div_zero) begin
            // Quotient all ones, remainder is the raw dividend.
            q_r        <= '1;
            acc_r      <= bus.A;
            m_r        <= '0;
            res_sign_r <= 1'b0;
          end else if (div_ovf) begin
            // Quotient is the dividend, remainder zero.
            q_r        <= bus.A;
            m_r        <= '0;
            res_sign_r <= 1'b0;
          end else if (is_div(bus.OP)) begin
            q_r        <= mag_a[WIDTH-1:0];
            m_r        <= mag_b;
            res_sign_r <= req_sign;
          end else begin
            q_r        <= mag_b[WIDTH-1:0];
            m_r        <= mag_a;
            res_sign_r <= req_sign;
          end
        end
        ST_CALC: begin
          cnt_r <= cnt_r - CW'(1);
          if (is_div(op_r)) begin
            acc_r <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            q_r   <= {q_r[WIDTH-2:0], div_ge};
          end else begin
            acc_r <= mul_sum[WIDTH:1];
            q_r   <= {mul_sum[0], q_r[WIDTH-1:1]};
          end
        end
        ST_FIN: begin
          y_r  <= res_y;
          dz_r <= dz_pend_r;
          of_r <= of_pend_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.IN_READY  = (state == ST_IDLE);
  assign bus.OUT_VALID = (state == ST_HOLD);
  assign bus.Y         = y_r;
  assign bus.DZ        = dz_r;
  assign bus.OF        = of_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_iterative_muldiv.sv
// Directed bench for iterative_muldiv (WIDTH=32).
module tb_iterative_muldiv;
  import muldiv_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     tests;
  int     fails;

  iterative_muldiv_if #(.WIDTH(32)) bus ();

  iterative_muldiv #(.WIDTH(32)) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE; returns after the acceptance edge.
  task automatic start_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    check32({tag, "_in_ready"}, 32'(bus.IN_READY), 32'd1);
    bus.IN_VALID = 1'b1;
    bus.OP       = op;
    bus.A        = a;
    bus.B        = b;
    tick();
    bus.IN_VALID = 1'b0;
  endtask

  // Edges from acceptance (acceptance edge counts as 1) until OUT_VALID is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (bus.OUT_VALID !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_y, input logic exp_dz,
                       input logic exp_of, input int exp_lat);
    int lat;
    start_op(tag, op, a, b);
    wait_out(lat);
    check32({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check32({tag, "_y"},  bus.Y, exp_y);
    check32({tag, "_dz"}, 32'(bus.DZ), 32'(exp_dz));
    check32({tag, "_of"}, 32'(bus.OF), 32'(exp_of));
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
  endtask

  initial begin
    int lat;
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.IN_VALID  = 1'b0;
    bus.OP        = 3'b000;
    bus.A         = '0;
    bus.B         = '0;
    bus.OUT_READY = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check32("rst_in_ready",  32'(bus.IN_READY),  32'd1);
    check32("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check32("rst_y",         bus.Y,              32'd0);
    check32("rst_dz",        32'(bus.DZ),        32'd0);
    check32("rst_of",        32'(bus.OF),        32'd0);
    check32("rst_state",     32'(dbg_state),     32'(ST_IDLE));

    // Multiply
    do_op("mul",      OP_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, 34);
    do_op("mulh",     OP_MULH,   32'h80000000,  32'h80000000, 32'h40000000, 1'b0, 1'b0, 34);
    do_op("mulhu",    OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 34);
    do_op("mulhsu",   OP_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 34);
    do_op("mul_mneg", OP_MUL,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 34);
    do_op("mulh_mng", OP_MULH,   32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 34);

    // Divide
    do_op("div",      OP_DIV,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0, 1'b0, 34);
    do_op("rem",      OP_REM,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 1'b0, 1'b0, 34);
    do_op("divu",     OP_DIVU,   32'd100,       32'd7,        32'd14,       1'b0, 1'b0, 34);
    do_op("remu",     OP_REMU,   32'd100,       32'd7,        32'd2,        1'b0, 1'b0, 34);
    do_op("div_nn",   OP_DIV,    32'hFFFFFFF9,  32'hFFFFFFFE, 32'd3,        1'b0, 1'b0, 34);
    do_op("rem_nn",   OP_REM,    32'hFFFFFFF9,  32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0, 34);
    do_op("div_mneg", OP_DIV,    32'h80000000,  32'd2,        32'hC0000000, 1'b0, 1'b0, 34);
    do_op("divu_max", OP_DIVU,   32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 34);

    // Special cases
    do_op("divu_z",   OP_DIVU,   32'd5,         32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 2);
    do_op("rem_z",    OP_REM,    32'd5,         32'd0,        32'd5,        1'b1, 1'b0, 2);
    do_op("div_of",   OP_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 2);
    do_op("rem_of",   OP_REM,    32'h80000000,  32'hFFFFFFFF, 32'd0,        1'b0, 1'b1, 2);

    // Backpressure: result held, new request ignored until handshake
    start_op("bp", OP_DIVU, 32'd100, 32'd7);
    wait_out(lat);
    check32("bp_lat", 32'(lat), 32'd34);
    bus.IN_VALID = 1'b1;
    bus.OP       = OP_MUL;
    bus.A        = 32'd6;
    bus.B        = 32'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      check32("bp_valid",    32'(bus.OUT_VALID), 32'd1);
      check32("bp_y",        bus.Y,              32'd14);
      check32("bp_dz",       32'(bus.DZ),        32'd0);
      check32("bp_of",       32'(bus.OF),        32'd0);
      check32("bp_in_ready", 32'(bus.IN_READY),  32'd0);
    end
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
    check32("bp_idle_ready", 32'(bus.IN_READY),  32'd1);
    check32("bp_idle_valid", 32'(bus.OUT_VALID), 32'd0);
    tick();
    bus.IN_VALID = 1'b0;
    check32("bp_accept_state", 32'(dbg_state), 32'(ST_CALC));
    check32("bp_accept_ready", 32'(bus.IN_READY), 32'd0);
    wait_out(lat);
    check32("bp2_lat", 32'(lat), 32'd34);
    check32("bp2_y",   bus.Y,    32'd42);
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;

    // Reset in the middle of a divide
    start_op("rstmid", OP_DIVU, 32'd1000, 32'd3);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check32("rstmid_valid", 32'(bus.OUT_VALID), 32'd0);
    check32("rstmid_ready", 32'(bus.IN_READY),  32'd1);
    check32("rstmid_y",     bus.Y,              32'd0);
    check32("rstmid_state", 32'(dbg_state),     32'(ST_IDLE));
    do_op("post_rst_mulhu", OP_MULHU, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
